// File: rtl/video_ts_dram_arb.sv
// Burst-locked arbiter of the video DRAM read port between the tilemap prefetcher (TM)
// and the TS renderer graphics fetcher (GR). Define VIDEO_TS_ARB_RR_EN for round-robin ties.
module video_ts_dram_arb #(
    parameter int BURST      = 8,
    parameter int STARVE_MAX = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic        tm_req,
    input  logic [20:0] tm_addr,
    output logic        tm_next,
    input  logic        gr_req,
    input  logic [20:0] gr_addr,
    output logic        gr_next,
    output logic        dram_req,
    output logic [20:0] dram_addr,
    input  logic        dram_next,
    output logic        busy,
    output logic        starve_flag
);

    typedef enum logic [1:0] {IDLE, G_TM, G_GR} state_t;

    state_t     state;
    state_t     state_nxt;
    state_t     tie_grant;
    logic [4:0] burst_cnt;
    logic [7:0] starve_cnt;
    logic       victim_gr;
    logic       cur_victim_gr;
    logic       own_req;
    logic       other_req;
    logic       victim_req;
    logic       starved;
    logic       served;
    logic       switch_pt;
    logic       burst_done;
    logic       leave;
    logic       forced;
    logic       grant_victim;

`ifdef VIDEO_TS_ARB_RR_EN
    logic last_gr;

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_gr <= 1'b1;
        else if (state_nxt == G_TM)
            last_gr <= 1'b0;
        else if (state_nxt == G_GR)
            last_gr <= 1'b1;
    end

    assign tie_grant = last_gr ? G_TM : G_GR;
`else
    assign tie_grant = G_TM;
`endif

    // The starvation counter always tracks whoever is not granted; in IDLE it
    // keeps tracking the loser of the last grant.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        own_req       = 1'b0;
        other_req     = 1'b0;
        cur_victim_gr = victim_gr;
        case (state)
            G_TM: begin
                own_req       = tm_req;
                other_req     = gr_req;
                cur_victim_gr = 1'b1;
            end
            G_GR: begin
                own_req       = gr_req;
                other_req     = tm_req;
                cur_victim_gr = 1'b0;
            end
            default: ;
        endcase
        victim_req = cur_victim_gr ? gr_req : tm_req;
        starved    = (starve_cnt == 8'(STARVE_MAX)) && victim_req;
        served     = (state != IDLE) && own_req && dram_next;
        // A word in flight (req high, no dram_next yet) pins the grant.
        switch_pt  = !own_req || dram_next;
        burst_done = served && (burst_cnt == 5'(BURST - 1));
        leave      = (state != IDLE) && (!own_req || burst_done || (starved && switch_pt));
        forced     = starved && ((state == IDLE) || switch_pt);
    end

    always_comb begin
        state_nxt = state;
        if (line_start) begin
            state_nxt = IDLE;
        end else if (state == IDLE) begin
            if (starved)
                state_nxt = cur_victim_gr ? G_GR : G_TM;
            else if (tm_req && gr_req)
                state_nxt = tie_grant;
            else if (tm_req)
                state_nxt = G_TM;
            else if (gr_req)
                state_nxt = G_GR;
        end else if (leave) begin
            if (other_req)
                state_nxt = (state == G_TM) ? G_GR : G_TM;
            else if (own_req)
                state_nxt = state;
            else
                state_nxt = IDLE;
        end
    end

    assign grant_victim = (state_nxt == G_GR &&  cur_victim_gr) ||
                          (state_nxt == G_TM && !cur_victim_gr);

    // NOTE: reset is synchronous, so it sits inside the clocked branch, and all state uses <=.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            burst_cnt   <= '0;
            starve_cnt  <= '0;
            starve_flag <= 1'b0;
            victim_gr   <= 1'b0;
        end else if (line_start) begin
            burst_cnt   <= '0;
            starve_cnt  <= '0;
            starve_flag <= 1'b0;
        end else begin
            if (leave)
                burst_cnt <= '0;
            else if (served)
                burst_cnt <= burst_cnt + 5'd1;

            if (grant_victim)
                starve_cnt <= '0;
            else if (state != IDLE && victim_req && starve_cnt != 8'(STARVE_MAX))
                starve_cnt <= starve_cnt + 8'd1;

            if (forced)
                starve_flag <= 1'b1;

            if (state_nxt == G_TM)
                victim_gr <= 1'b1;
            else if (state_nxt == G_GR)
                victim_gr <= 1'b0;
        end
    end

    // Next strobes are suppressed while reset is asserted so no word is claimed mid-reset.
    always_comb begin
        dram_req  = 1'b0;
        dram_addr = '0;
        tm_next   = 1'b0;
        gr_next   = 1'b0;
        case (state)
            G_TM: begin
                dram_req  = tm_req;
                dram_addr = tm_addr;
                tm_next   = dram_next & tm_req & rst_n;
            end
            G_GR: begin
                dram_req  = gr_req;
                dram_addr = gr_addr;
                gr_next   = dram_next & gr_req & rst_n;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_video_ts_dram_arb.sv
// Directed bench for video_ts_dram_arb: default instance plus a BURST=16/STARVE_MAX=4 instance.
module tb_video_ts_dram_arb;

    localparam logic [20:0] A_T = 21'h12345;
    localparam logic [20:0] A_G = 21'h06789;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        line_start;
    logic        tm_req;
    logic        gr_req;
    logic        dram_next;
    logic [20:0] tm_addr = A_T;
    logic [20:0] gr_addr = A_G;

    logic        tm_next, gr_next, dram_req, busy, starve_flag;
    logic [20:0] dram_addr;
    logic        s_tm_next, s_gr_next, s_dram_req, s_busy, s_starve_flag;
    logic [20:0] s_dram_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    video_ts_dram_arb dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start),
        .tm_req(tm_req), .tm_addr(tm_addr), .tm_next(tm_next),
        .gr_req(gr_req), .gr_addr(gr_addr), .gr_next(gr_next),
        .dram_req(dram_req), .dram_addr(dram_addr), .dram_next(dram_next),
        .busy(busy), .starve_flag(starve_flag)
    );

    video_ts_dram_arb #(.BURST(16), .STARVE_MAX(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .line_start(line_start),
        .tm_req(tm_req), .tm_addr(tm_addr), .tm_next(s_tm_next),
        .gr_req(gr_req), .gr_addr(gr_addr), .gr_next(s_gr_next),
        .dram_req(s_dram_req), .dram_addr(s_dram_addr), .dram_next(dram_next),
        .busy(s_busy), .starve_flag(s_starve_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge; outputs are sampled 1 unit later.
    task automatic cyc(input logic t, input logic g, input logic dn, input logic ls);
        @(negedge clk);
        tm_req     = t;
        gr_req     = g;
        dram_next  = dn;
        line_start = ls;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        tm_req     = 1'b0;
        gr_req     = 1'b0;
        dram_next  = 1'b0;
        line_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset held with both requesting
        rst_n = 1'b0; tm_req = 1'b1; gr_req = 1'b1; dram_next = 1'b0; line_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dram_req", dram_req, 0);
        check("rst_busy", busy, 0);
        check("rst_starve_flag", starve_flag, 0);
        check("rst_dram_addr", dram_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_idle_busy", busy, 0);
        check("release_idle_req", dram_req, 0);

        // Burst lock: 8 TM words, 8 GR words, then TM again
        for (int i = 0; i < 17; i++) begin
            cyc(1, 1, 1, 0);
            if (i == 0) begin
                check("first_grant_busy", busy, 1);
                check("first_grant_req", dram_req, 1);
            end
            check($sformatf("burst_next_%0d", i), {tm_next, gr_next},
                  (i < 8 || i == 16) ? 2'b10 : 2'b01);
            check($sformatf("burst_addr_%0d", i), dram_addr,
                  (i < 8 || i == 16) ? A_T : A_G);
        end

        // Reset asserted mid-grant with dram_next high: no strobe
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tm_next", tm_next, 0);
        @(negedge clk);
        #1;
        check("midrst_busy", busy, 0);
        do_reset();

        // Early release: TM drops after 3 words, GR follows with no IDLE bubble
        cyc(1, 1, 0, 0);
        check("er_idle", busy, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 1, 0);
            check($sformatf("er_tm_word_%0d", i), tm_next, 1);
        end
        cyc(0, 1, 0, 0);
        check("er_drop_req", dram_req, 0);
        check("er_drop_addr", dram_addr, A_T);
        cyc(0, 1, 1, 0);
        check("er_gr_busy", busy, 1);
        check("er_gr_addr", dram_addr, A_G);
        check("er_gr_next", gr_next, 1);

        // Starvation on BURST=16/STARVE_MAX=4 instance, dram_next on even cycles
        do_reset();
        cyc(1, 1, 0, 0);
        check("sv_idle", s_busy, 0);
        for (int j = 1; j <= 8; j++) begin
            cyc(1, 1, (j % 2 == 0), 0);
            case (j)
                1: check("sv_j1_addr", s_dram_addr, A_T);
                4: check("sv_j4_tm_next", s_tm_next, 1);
                5: begin
                    check("sv_j5_addr", s_dram_addr, A_T);
                    check("sv_j5_flag", s_starve_flag, 0);
                end
                6: begin
                    check("sv_j6_tm_next", s_tm_next, 1);
                    check("sv_j6_flag", s_starve_flag, 0);
                end
                7: begin
                    check("sv_j7_addr", s_dram_addr, A_G);
                    check("sv_j7_flag", s_starve_flag, 1);
                    check("sv_j7_gr_next", s_gr_next, 0);
                    check("sv_j7_req", s_dram_req, 1);
                end
                8: check("sv_j8_gr_next", s_gr_next, 1);
                default: ;
            endcase
        end

        // line_start coincident with dram_next in G_GR
        cyc(1, 1, 1, 1);
        check("ls_gr_next", s_gr_next, 1);
        check("ls_flag_before", s_starve_flag, 1);
        cyc(1, 1, 0, 0);
        check("ls_idle", s_busy, 0);
        check("ls_flag_clear", s_starve_flag, 0);

        // line_start mid TM burst clears burst count: full 8 words after
        do_reset();
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0);
        cyc(1, 1, 1, 1);
        check("lsb_tm_next", tm_next, 1);
        cyc(1, 1, 0, 0);
        check("lsb_idle", busy, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 1, 0);
            check($sformatf("lsb_tm_word_%0d", i), tm_next, 1);
        end
        cyc(1, 1, 1, 0);
        check("lsb_gr_after", gr_next, 1);
        check("lsb_gr_addr", dram_addr, A_G);

        // IDLE tie-break after a GR burst, then after a TM burst
        do_reset();
        cyc(0, 1, 0, 0);
        check("tie_idle0", busy, 0);
        cyc(0, 1, 1, 0);
        check("tie_gr_addr", dram_addr, A_G);
        check("tie_gr_next", gr_next, 1);
        cyc(0, 1, 1, 0);
        cyc(0, 0, 0, 0);
        check("tie_gr_drop_req", dram_req, 0);
        cyc(1, 1, 0, 0);
        check("tie_idle1", busy, 0);
        cyc(1, 1, 1, 0);
        check("tie_after_gr_addr", dram_addr, A_T);
        check("tie_after_gr_next", tm_next, 1);
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        check("tie_idle2", busy, 0);
        cyc(1, 1, 0, 0);
`ifdef VIDEO_TS_ARB_RR_EN
        check("tie_after_tm_addr", dram_addr, A_G);
`else
        check("tie_after_tm_addr", dram_addr, A_T);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
